// File: rtl/pipe_stage_skid_reg_if.sv
// Valid/ready payload channel between two pipeline stages.
// The master drives valid and data; the slave answers with ready.
interface pipe_stage_skid_reg_if #(
    parameter int unsigned DATA_W = 279
) ();

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline-stage register with a two-entry skid buffer (main + skid).
// The hazard unit controls the stage through stall_i and bubble_i; bubble wins over stall.
// Upstream sees a registered ready. Saturating bubble/stall counters support performance
// monitoring.
module pipe_stage_skid_reg #(
    parameter int unsigned              DATA_W     = 279,
    parameter logic [DATA_W-1:0]        BUBBLE_VAL = '0,
    parameter int unsigned              CNT_W      = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    pipe_stage_skid_reg_if.slave        in_if,
    pipe_stage_skid_reg_if.master       out_if,
    output logic                        out_bubble_o,
    input  logic                        stall_i,
    input  logic                        bubble_i,
    output logic [1:0]                  occupancy_o,
    output logic [CNT_W-1:0]            bubble_cnt_o,
    output logic [CNT_W-1:0]            stall_cnt_o
);

    // Main entry drives the output directly; skid catches the beat that arrives while the
    // downstream (or a stall) holds main.
    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic              r_main_bubble;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_in_ready;
    logic [CNT_W-1:0]  r_bubble_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_main_valid_d;
    logic [DATA_W-1:0] w_main_data_d;
    logic              w_main_bubble_d;
    logic              w_skid_valid_d;
    logic [DATA_W-1:0] w_skid_data_d;
    logic              w_in_ready_d;
    logic [CNT_W-1:0]  w_bubble_cnt_d;
    logic [CNT_W-1:0]  w_stall_cnt_d;

    logic              w_in_fire;
    logic              w_out_fire;

    assign w_in_fire  = in_if.valid & r_in_ready;
    assign w_out_fire = r_main_valid & out_if.ready & ~stall_i;

    // Next-state for main/skid storage; bubble overrides everything, stall only blocks out_fire.
    always_comb begin
        w_main_valid_d  = r_main_valid;
        w_main_data_d   = r_main_data;
        w_main_bubble_d = r_main_bubble;
        w_skid_valid_d  = r_skid_valid;
        w_skid_data_d   = r_skid_data;

        if (bubble_i) begin
            // Flush: any accepted input this cycle is dropped on purpose.
            w_main_valid_d  = 1'b1;
            w_main_data_d   = BUBBLE_VAL;
            w_main_bubble_d = 1'b1;
            w_skid_valid_d  = 1'b0;
        end else if (r_skid_valid) begin
            if (w_out_fire) begin
                w_main_data_d   = r_skid_data;
                w_main_bubble_d = 1'b0;
                w_skid_valid_d  = w_in_fire;
                if (w_in_fire) begin
                    w_skid_data_d = in_if.data;
                end
            end
        end else if (!r_main_valid) begin
            if (w_in_fire) begin
                w_main_valid_d  = 1'b1;
                w_main_data_d   = in_if.data;
                w_main_bubble_d = 1'b0;
            end
        end else if (w_out_fire) begin
            if (w_in_fire) begin
                w_main_data_d   = in_if.data;
                w_main_bubble_d = 1'b0;
            end else begin
                w_main_valid_d  = 1'b0;
                w_main_bubble_d = 1'b0;
            end
        end else if (w_in_fire) begin
            w_skid_valid_d = 1'b1;
            w_skid_data_d  = in_if.data;
        end

        w_in_ready_d = ~w_skid_valid_d;
    end

    // Saturating performance counters.
    always_comb begin
        w_bubble_cnt_d = r_bubble_cnt;
        w_stall_cnt_d  = r_stall_cnt;
        if (bubble_i && (r_bubble_cnt != {CNT_W{1'b1}})) begin
            w_bubble_cnt_d = r_bubble_cnt + CNT_W'(1);
        end
        if (stall_i && r_main_valid && (r_stall_cnt != {CNT_W{1'b1}})) begin
            w_stall_cnt_d = r_stall_cnt + CNT_W'(1);
        end
    end

    // Control and main-entry state with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_main_valid  <= 1'b0;
            r_main_data   <= BUBBLE_VAL;
            r_main_bubble <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_in_ready    <= 1'b1;
            r_bubble_cnt  <= '0;
            r_stall_cnt   <= '0;
        end else begin
            r_main_valid  <= w_main_valid_d;
            r_main_data   <= w_main_data_d;
            r_main_bubble <= w_main_bubble_d;
            r_skid_valid  <= w_skid_valid_d;
            r_in_ready    <= w_in_ready_d;
            r_bubble_cnt  <= w_bubble_cnt_d;
            r_stall_cnt   <= w_stall_cnt_d;
        end
    end

    // Skid payload is only meaningful while r_skid_valid is set, so it needs no reset.
    always_ff @(posedge clk_i) begin
        r_skid_data <= w_skid_data_d;
    end

    assign in_if.ready  = r_in_ready;
    assign out_if.valid = r_main_valid;
    assign out_if.data  = r_main_data;
    assign out_bubble_o = r_main_bubble;
    assign occupancy_o  = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
    assign bubble_cnt_o = r_bubble_cnt;
    assign stall_cnt_o  = r_stall_cnt;

endmodule
